// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of arbitrary depth with occupancy count, almost flags and error pulses.
// Standard mode registers dout on each accepted read; FWFT mode presents the head word directly.
module sync_fifo_flags #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 10,
    parameter string       FIFO_TYPE  = "Standard",
    parameter int          AF_THRESH  = 8,
    parameter int          AE_THRESH  = 2,
    localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned    PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0]  PtrLast = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]  Depth   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  AfLevel = CW'(AF_THRESH);
    localparam logic [CW-1:0]  AeLevel = CW'(AE_THRESH);
    localparam bit             IsFwft  = (FIFO_TYPE == "FWFT");

    if (FIFO_DEPTH < 2) begin : g_chk_depth
        $error("sync_fifo_flags: FIFO_DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > int'(FIFO_DEPTH)) begin : g_chk_af
        $error("sync_fifo_flags: AF_THRESH must be in 1..FIFO_DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > int'(FIFO_DEPTH) - 1) begin : g_chk_ae
        $error("sync_fifo_flags: AE_THRESH must be in 0..FIFO_DEPTH-1");
    end
    if (FIFO_TYPE != "Standard" && FIFO_TYPE != "FWFT") begin : g_chk_type
        $error("sync_fifo_flags: FIFO_TYPE must be \"Standard\" or \"FWFT\"");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  empty_int, full_int;
    logic                  rd_ok, wr_ok;

    assign empty_int = (count_q == '0);
    assign full_int  = (count_q == Depth);

    // A full FIFO can take a write only when the same edge frees a slot.
    assign rd_ok = rd_en & ~empty_int;
    assign wr_ok = wr_en & (~full_int | rd_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en & ~wr_ok;
        underflow_d = rd_en & empty_int;

        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not cleared by reset; only a write colliding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    if (!IsFwft) begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  valid_q, valid_d;

        always_comb begin
            dout_d  = dout_q;
            valid_d = rd_ok;
            if (rd_ok) begin
                dout_d = mem_q[rd_ptr_q];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_d;
                valid_q <= valid_d;
            end
        end

        assign dout  = dout_q;
        assign valid = valid_q;
    end else begin : g_fwft
        // Gate the head word so dout reads zero whenever nothing is stored.
        assign dout  = empty_int ? '0 : mem_q[rd_ptr_q];
        assign valid = ~empty_int;
    end

    assign empty        = empty_int;
    assign full         = full_int;
    assign almost_empty = (count_q <= AeLevel);
    assign almost_full  = (count_q >= AfLevel);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench driving a Standard and an FWFT instance with identical stimulus.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en;
    logic [7:0] din;

    logic [7:0] s_dout, f_dout;
    logic       s_valid, s_empty, s_full, s_ae, s_af, s_ov, s_uf;
    logic       f_valid, f_empty, f_full, f_ae, f_af, f_ov, f_uf;
    logic [3:0] s_count, f_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [18:0] RstVec = {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    logic [18:0] s_vec, f_vec;
    assign s_vec = {s_count, s_empty, s_full, s_ae, s_af, s_ov, s_uf, s_valid, s_dout};
    assign f_vec = {f_count, f_empty, f_full, f_ae, f_af, f_ov, f_uf, f_valid, f_dout};

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DATA_WIDTH(8), .FIFO_DEPTH(10), .FIFO_TYPE("Standard"), .AF_THRESH(8), .AE_THRESH(2)
    ) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .valid(s_valid), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
        .overflow(s_ov), .underflow(s_uf)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(8), .FIFO_DEPTH(10), .FIFO_TYPE("FWFT"), .AF_THRESH(8), .AE_THRESH(2)
    ) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .valid(f_valid), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ov), .underflow(f_uf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        step();
        rst = 1'b0;
        vec_cnt++;
        if (s_vec !== RstVec) begin
            err_cnt++; $display("FAIL reset_std: got %h want %h", s_vec, RstVec);
        end
        vec_cnt++;
        if (f_vec !== RstVec) begin
            err_cnt++; $display("FAIL reset_fwft: got %h want %h", f_vec, RstVec);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_s, exp_f;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; din = 8'(i + 1);
            step();
            exp_s = {4'(i + 1), i == 9, i >= 7, i <= 1, 1'b0};
            vec_cnt++;
            if ({s_count, s_full, s_af, s_ae, s_valid} !== exp_s) begin
                err_cnt++;
                $display("FAIL fill_std[%0d]: got %b want %b", i,
                         {s_count, s_full, s_af, s_ae, s_valid}, exp_s);
            end
            exp_f = {4'(i + 1), i == 9, i >= 7, i <= 1, 1'b1};
            vec_cnt++;
            if ({f_count, f_full, f_af, f_ae, f_valid, f_dout} !== {exp_f, 8'h01}) begin
                err_cnt++;
                $display("FAIL fill_fwft[%0d]: got %b/%h want %b/01", i,
                         {f_count, f_full, f_af, f_ae, f_valid}, f_dout, exp_f);
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vec_cnt++;
            if ({f_valid, f_dout} !== {1'b1, 8'(i + 1)}) begin
                err_cnt++;
                $display("FAIL drain_fwft_head[%0d]: got %b/%h want 1/%h", i,
                         f_valid, f_dout, 8'(i + 1));
            end
            rd_en = 1'b1;
            step();
            vec_cnt++;
            if ({s_valid, s_dout, s_count, f_count} !== {1'b1, 8'(i + 1), 4'(9 - i), 4'(9 - i)})
            begin
                err_cnt++;
                $display("FAIL drain_std[%0d]: got v=%b d=%h c=%0d/%0d want v=1 d=%h c=%0d",
                         i, s_valid, s_dout, s_count, f_count, 8'(i + 1), 9 - i);
            end
        end
        rd_en = 1'b0;
        step();
        vec_cnt++;
        if ({s_empty, f_empty, s_valid, f_valid, s_dout, s_uf} !== {4'b1100, 8'h0A, 1'b0}) begin
            err_cnt++;
            $display("FAIL drain_end: got e=%b%b v=%b%b d=%h uf=%b want e=11 v=00 d=0a uf=0",
                     s_empty, f_empty, s_valid, f_valid, s_dout, s_uf);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] wv = 8'h10;
        logic [7:0] rv = 8'h10;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 7; j++) begin
                wr_en = 1'b1; din = wv; wv++;
                step();
                vec_cnt++;
                if ({s_count, f_count} !== {4'(j + 1), 4'(j + 1)}) begin
                    err_cnt++;
                    $display("FAIL wrap_wr_count[%0d.%0d]: got %0d/%0d want %0d",
                             r, j, s_count, f_count, j + 1);
                end
            end
            wr_en = 1'b0;
            for (int j = 0; j < 7; j++) begin
                vec_cnt++;
                if (f_dout !== rv) begin
                    err_cnt++;
                    $display("FAIL wrap_fwft[%0d.%0d]: got %h want %h", r, j, f_dout, rv);
                end
                rd_en = 1'b1;
                step();
                vec_cnt++;
                if ({s_valid, s_dout, s_count, f_count} !== {1'b1, rv, 4'(6 - j), 4'(6 - j)})
                begin
                    err_cnt++;
                    $display("FAIL wrap_std[%0d.%0d]: got v=%b d=%h c=%0d/%0d want d=%h c=%0d",
                             r, j, s_valid, s_dout, s_count, f_count, rv, 6 - j);
                end
                rv++;
            end
            rd_en = 1'b0;
        end
    endtask

    task automatic test_full_simul();
        logic [7:0] exp;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; din = 8'h20 + 8'(i);
            step();
        end
        wr_en = 1'b1; rd_en = 1'b1; din = 8'hAA;
        step();
        vec_cnt++;
        if ({s_count, s_full, s_ov, s_valid, s_dout} !== {4'd10, 3'b101, 8'h20}) begin
            err_cnt++;
            $display("FAIL full_rw_std: got c=%0d f=%b ov=%b v=%b d=%h want c=10 f=1 ov=0 v=1 d=20",
                     s_count, s_full, s_ov, s_valid, s_dout);
        end
        vec_cnt++;
        if ({f_count, f_full, f_ov, f_valid, f_dout} !== {4'd10, 3'b101, 8'h21}) begin
            err_cnt++;
            $display("FAIL full_rw_fwft: got c=%0d f=%b ov=%b v=%b d=%h want c=10 f=1 ov=0 v=1 d=21",
                     f_count, f_full, f_ov, f_valid, f_dout);
        end
        rd_en = 1'b0; din = 8'hBB;
        step();
        wr_en = 1'b0;
        vec_cnt++;
        if ({s_count, s_ov, s_valid, f_count, f_ov} !== {4'd10, 2'b10, 4'd10, 1'b1}) begin
            err_cnt++;
            $display("FAIL overflow: got c=%0d/%0d ov=%b/%b v=%b want c=10 ov=1 v=0",
                     s_count, f_count, s_ov, f_ov, s_valid);
        end
        step();
        vec_cnt++;
        if ({s_ov, f_ov} !== 2'b00) begin
            err_cnt++; $display("FAIL overflow_pulse: got %b%b want 00", s_ov, f_ov);
        end
        for (int i = 0; i < 10; i++) begin
            exp = (i < 9) ? 8'h21 + 8'(i) : 8'hAA;
            vec_cnt++;
            if (f_dout !== exp) begin
                err_cnt++; $display("FAIL full_drain_fwft[%0d]: got %h want %h", i, f_dout, exp);
            end
            rd_en = 1'b1;
            step();
            vec_cnt++;
            if (s_dout !== exp) begin
                err_cnt++; $display("FAIL full_drain_std[%0d]: got %h want %h", i, s_dout, exp);
            end
        end
        rd_en = 1'b0;
        vec_cnt++;
        if ({s_empty, f_empty, s_count} !== {2'b11, 4'd0}) begin
            err_cnt++;
            $display("FAIL full_drain_empty: got e=%b%b c=%0d want e=11 c=0", s_empty, f_empty,
                     s_count);
        end
    endtask

    task automatic test_empty_simul();
        step();
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h55;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        vec_cnt++;
        if ({s_uf, s_count, s_valid} !== {1'b1, 4'd1, 1'b0}) begin
            err_cnt++;
            $display("FAIL empty_rw_std: got uf=%b c=%0d v=%b want uf=1 c=1 v=0",
                     s_uf, s_count, s_valid);
        end
        vec_cnt++;
        if ({f_uf, f_count, f_valid, f_dout} !== {1'b1, 4'd1, 1'b1, 8'h55}) begin
            err_cnt++;
            $display("FAIL empty_rw_fwft: got uf=%b c=%0d v=%b d=%h want uf=1 c=1 v=1 d=55",
                     f_uf, f_count, f_valid, f_dout);
        end
        step();
        vec_cnt++;
        if ({s_uf, f_uf, f_valid, f_dout, s_valid} !== {3'b001, 8'h55, 1'b0}) begin
            err_cnt++;
            $display("FAIL underflow_pulse: got uf=%b%b fv=%b fd=%h sv=%b want uf=00 fv=1 fd=55 sv=0",
                     s_uf, f_uf, f_valid, f_dout, s_valid);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        vec_cnt++;
        if ({s_valid, s_dout} !== {1'b1, 8'h55}) begin
            err_cnt++;
            $display("FAIL latency_std: got v=%b d=%h want v=1 d=55", s_valid, s_dout);
        end
        step();
        vec_cnt++;
        if ({s_valid, s_empty, f_valid, f_empty} !== 4'b0101) begin
            err_cnt++;
            $display("FAIL latency_std_after: got sv=%b se=%b fv=%b fe=%b want 0 1 0 1",
                     s_valid, s_empty, f_valid, f_empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; din = 8'h60 + 8'(i);
            step();
        end
        vec_cnt++;
        if ({s_count, f_count, s_ae, s_af} !== {4'd6, 4'd6, 2'b00}) begin
            err_cnt++;
            $display("FAIL pre_reset: got c=%0d/%0d ae=%b af=%b want c=6 ae=0 af=0",
                     s_count, f_count, s_ae, s_af);
        end
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h99; rst = 1'b1;
        step();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        vec_cnt++;
        if (s_vec !== RstVec) begin
            err_cnt++; $display("FAIL reset_mid_std: got %h want %h", s_vec, RstVec);
        end
        vec_cnt++;
        if (f_vec !== RstVec) begin
            err_cnt++; $display("FAIL reset_mid_fwft: got %h want %h", f_vec, RstVec);
        end
        step();
        vec_cnt++;
        if ({s_vec, f_vec} !== {RstVec, RstVec}) begin
            err_cnt++;
            $display("FAIL reset_mid_hold: got %h/%h want %h", s_vec, f_vec, RstVec);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_simul();
        test_empty_simul();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
